// File: rtl/hyb_pkg.sv
// Shared constants and helpers for the hybrid AES->Blowfish operand loader.
package hyb_pkg;
  localparam int unsigned NIBBLES = 32;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned OP_W    = 128;
  localparam int unsigned CNT_NW  = 5;

  localparam logic [1:0] ST_DATA  = 2'b00;
  localparam logic [1:0] ST_KEY   = 2'b01;
  localparam logic [1:0] ST_READY = 2'b10;

  // Oldest nibble ends up in the top bits after a full operand is entered.
  function automatic logic [OP_W-1:0] shift_nib(input logic [OP_W-1:0]  op,
                                                input logic [NIB_W-1:0] nib);
    return {op[OP_W-NIB_W-1:0], nib};
  endfunction
endpackage

// File: rtl/hyb_btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, counted debounce, rising-edge pulse.
module hyb_btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_W           = 18
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic rise_pulse
);
  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive cycles of disagreement; any agreement restarts the count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    rise_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level      = level_q;
  assign rise_pulse = rise_q;
endmodule

// File: rtl/hyb_input_loader.sv
// Collects a 128-bit plaintext then a 128-bit key, one switch nibble per debounced
// LOAD press, and holds both stable with a ready flag for the encryption datapath.
module hyb_input_loader
  import hyb_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_W           = 18
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NIB_W-1:0]    nib_in,
  input  logic                btn_load,
  input  logic                btn_clear,
  output logic [OP_W-1:0]     data_bin,
  output logic [OP_W-1:0]     key_bin,
  output logic                block_valid,
  output logic [1:0]          load_state,
  output logic [CNT_NW-1:0]   nib_count
);
  logic              load_lvl, load_rise, clear_lvl, clear_rise;
  logic              load_p, clear_p, last_nib;
  logic [1:0]        state_q, state_d;
  logic [OP_W-1:0]   data_q, data_d, key_q, key_d;
  logic [CNT_NW-1:0] cnt_q, cnt_d;
  logic              valid_q, valid_d;

  hyb_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_load_db (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_load),
    .level      (load_lvl),
    .rise_pulse (load_rise)
  );

  hyb_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_clear_db (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_clear),
    .level      (clear_lvl),
    .rise_pulse (clear_rise)
  );

  // A rise pulse only ever coincides with a pressed level; the AND is a consistency guard.
  assign load_p   = load_rise & load_lvl;
  assign clear_p  = clear_rise & clear_lvl;
  assign last_nib = (cnt_q == CNT_NW'(NIBBLES - 1));

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    if (clear_p) begin
      state_d = ST_DATA;
      data_d  = '0;
      key_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_DATA: begin
          if (load_p) begin
            data_d = shift_nib(data_q, nib_in);
            if (last_nib) begin
              cnt_d   = '0;
              state_d = ST_KEY;
            end else begin
              cnt_d = cnt_q + CNT_NW'(1);
            end
          end
        end
        ST_KEY: begin
          if (load_p) begin
            key_d = shift_nib(key_q, nib_in);
            if (last_nib) begin
              cnt_d   = '0;
              state_d = ST_READY;
            end else begin
              cnt_d = cnt_q + CNT_NW'(1);
            end
          end
        end
        ST_READY: state_d = ST_READY;
        default: begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end
      endcase
    end
    valid_d = (state_d == ST_READY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_DATA;
      data_q  <= '0;
      key_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign data_bin    = data_q;
  assign key_bin     = key_q;
  assign block_valid = valid_q;
  assign load_state  = state_q;
  assign nib_count   = cnt_q;
endmodule

// File: tb/tb_hyb_input_loader.sv
// Bench for hyb_input_loader: vector table, corner sequences, random presses vs. a history-based model.
module tb_hyb_input_loader;
  localparam int unsigned DB = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   nib_in = '0;
  logic         btn_load = 1'b0;
  logic         btn_clear = 1'b0;
  logic [127:0] data_bin, key_bin;
  logic         block_valid;
  logic [1:0]   load_state;
  logic [4:0]   nib_count;

  int checks = 0;
  int failures = 0;

  hyb_input_loader #(.DEBOUNCE_CYCLES(DB), .CNT_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .nib_in      (nib_in),
    .btn_load    (btn_load),
    .btn_clear   (btn_clear),
    .data_bin    (data_bin),
    .key_bin     (key_bin),
    .block_valid (block_valid),
    .load_state  (load_state),
    .nib_count   (nib_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: raw button history per edge; operands kept as nibble lists.
  logic [3:0]  dq[$];
  logic [3:0]  kq[$];
  int          phase;
  logic [DB+1:0] lh, ch;
  logic        llvl, clvl, mld, mclr;

  function automatic logic [127:0] pack(input logic [3:0] q[$]);
    logic [127:0] v = '0;
    foreach (q[i]) v = (v << 4) | 128'(q[i]);
    return v;
  endfunction

  // Level flips once the synchronised samples (2+ edges old) disagreed DB times running.
  function automatic bit flips(input logic [DB+1:0] h, input logic lvl);
    for (int k = 2; k <= DB + 1; k++) if (h[k] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_reset();
    dq.delete(); kq.delete();
    phase = 0; lh = '0; ch = '0;
    llvl = 1'b0; clvl = 1'b0; mld = 1'b0; mclr = 1'b0;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_reset();
      end else begin
        if (mclr) begin
          dq.delete(); kq.delete(); phase = 0;
        end else if (mld && phase < 2) begin
          if (phase == 0) begin
            dq.push_back(nib_in);
            if (dq.size() == 32) phase = 1;
          end else begin
            kq.push_back(nib_in);
            if (kq.size() == 32) phase = 2;
          end
        end
        lh = {lh[DB:0], btn_load};
        ch = {ch[DB:0], btn_clear};
        mld = 1'b0; mclr = 1'b0;
        if (flips(lh, llvl)) begin llvl = ~llvl; mld = llvl; end
        if (flips(ch, clvl)) begin clvl = ~clvl; mclr = clvl; end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("m_data", data_bin, pack(dq));
      check("m_key", key_bin, pack(kq));
      check("m_state", 128'(load_state), 128'(phase));
      check("m_valid", 128'(block_valid), 128'(phase == 2));
      check("m_count", 128'(nib_count),
            128'((phase == 0) ? dq.size() : (phase == 1) ? kq.size() : 0));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] nb);
    nib_in = nb; btn_load = 1'b1; cyc(DB + 4);
    btn_load = 1'b0; cyc(DB + 4);
  endtask

  task automatic clr();
    btn_clear = 1'b1; cyc(DB + 4);
    btn_clear = 1'b0; cyc(DB + 4);
  endtask

  typedef struct {
    int           n;
    logic [3:0]   start;
    int           step;
    bit           clr;
    logic [1:0]   st;
    logic [4:0]   cnt;
    logic         bv;
    logic [127:0] d;
    logic [127:0] k;
  } vec_t;

  localparam logic [127:0] DPAT = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] KPAT = 128'hFEDCBA9876543210FEDCBA9876543210;

  initial begin
    vec_t tbl[7];
    int   r;
    tbl[0] = '{32, 4'h0,  1, 1'b0, 2'b01, 5'd0,  1'b0, DPAT, 128'h0};
    tbl[1] = '{32, 4'hF, -1, 1'b0, 2'b10, 5'd0,  1'b1, DPAT, KPAT};
    tbl[2] = '{1,  4'hA,  0, 1'b0, 2'b10, 5'd0,  1'b1, DPAT, KPAT};
    tbl[3] = '{0,  4'h0,  0, 1'b1, 2'b00, 5'd0,  1'b0, 128'h0, 128'h0};
    tbl[4] = '{32, 4'h0,  1, 1'b0, 2'b01, 5'd0,  1'b0, DPAT, 128'h0};
    tbl[5] = '{10, 4'h5,  1, 1'b0, 2'b01, 5'd10, 1'b0, DPAT, 128'h56789ABCDE};
    tbl[6] = '{0,  4'h0,  0, 1'b1, 2'b00, 5'd0,  1'b0, 128'h0, 128'h0};

    cyc(3);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("rst_data", data_bin, 128'h0);
    check("rst_key", key_bin, 128'h0);
    check("rst_valid", 128'(block_valid), 128'h0);
    check("rst_state", 128'(load_state), 128'h0);
    check("rst_count", 128'(nib_count), 128'h0);

    // Too-short press is swallowed by the debouncer.
    cyc(1);
    btn_load = 1'b1; cyc(3);
    btn_load = 1'b0; cyc(12);
    @(negedge clk);
    check("short_count", 128'(nib_count), 128'h0);
    check("short_data", data_bin, 128'h0);

    // Bounce then a clean hold: one capture, 7 edges after the final rise.
    cyc(1);
    nib_in = 4'h7;
    btn_load = 1'b1; cyc(1); btn_load = 1'b0; cyc(1);
    btn_load = 1'b1; cyc(1); btn_load = 1'b0; cyc(1);
    btn_load = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("bounce_count_e%0d", i), 128'(nib_count), 128'((i >= 7) ? 1 : 0));
    end
    btn_load = 1'b0; cyc(DB + 4);
    @(negedge clk);
    check("bounce_data", data_bin, 128'h7);
    cyc(1);
    clr();

    for (int v = 0; v < 7; v++) begin
      if (tbl[v].clr) clr();
      else for (int j = 0; j < tbl[v].n; j++) press(4'(int'(tbl[v].start) + tbl[v].step * j));
      @(negedge clk);
      check($sformatf("v%0d_data", v), data_bin, tbl[v].d);
      check($sformatf("v%0d_key", v), key_bin, tbl[v].k);
      check($sformatf("v%0d_state", v), 128'(load_state), 128'(tbl[v].st));
      check($sformatf("v%0d_count", v), 128'(nib_count), 128'(tbl[v].cnt));
      check($sformatf("v%0d_valid", v), 128'(block_valid), 128'(tbl[v].bv));
      cyc(1);
    end

    // LOAD and CLEAR pressed together: clear wins, nibble discarded.
    press(4'h1); press(4'h2); press(4'h3);
    nib_in = 4'h9; btn_load = 1'b1; btn_clear = 1'b1; cyc(DB + 4);
    btn_load = 1'b0; btn_clear = 1'b0; cyc(DB + 4);
    @(negedge clk);
    check("both_data", data_bin, 128'h0);
    check("both_count", 128'(nib_count), 128'h0);
    check("both_state", 128'(load_state), 128'h0);
    cyc(1);

    // Asynchronous reset in the middle of key entry.
    for (int j = 0; j < 32; j++) press(4'(j * 3));
    for (int j = 0; j < 5; j++) press(4'(j + 8));
    @(negedge clk);
    check("pre_rst_state", 128'(load_state), 128'h1);
    check("pre_rst_count", 128'(nib_count), 128'd5);
    cyc(1);
    rst_n = 1'b0;
    #1;
    check("arst_data", data_bin, 128'h0);
    check("arst_key", key_bin, 128'h0);
    check("arst_state", 128'(load_state), 128'h0);
    check("arst_count", 128'(nib_count), 128'h0);
    check("arst_valid", 128'(block_valid), 128'h0);
    @(negedge clk); rst_n = 1'b1;
    cyc(2);

    // Random presses, glitches and clears against the model.
    for (int it = 0; it < 80; it++) begin
      nib_in = 4'($urandom);
      r = int'($urandom_range(0, 9));
      if (r == 0) btn_clear = 1'b1;
      else if (r == 1) begin btn_clear = 1'b1; btn_load = 1'b1; end
      else btn_load = 1'b1;
      cyc(int'($urandom_range(1, DB + 4)));
      btn_load = 1'b0; btn_clear = 1'b0;
      cyc(int'($urandom_range(1, DB + 4)));
    end
    cyc(DB + 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
